// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: aligns loads/stores onto a word-wide req/gnt/rvalid bus,
// stalls the pipeline until the response, and reports misalignment and bus timeouts.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_memAddr,
    input  logic [31:0] i_wrData,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_readData,
    output logic        o_misalign,
    output logic        o_busErr,
    output logic        o_busReq,
    output logic        o_busWe,
    output logic [31:0] o_busAddr,
    output logic [31:0] o_busWdata,
    output logic [3:0]  o_busBe,
    input  logic        i_busGnt,
    input  logic        i_busRvalid,
    input  logic [31:0] i_busRdata
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [1:0]       r_lane;
    logic [2:0]       r_funct3;
    logic             r_isLoad;
    logic             r_done, r_misalign, r_busErr, r_busReq, r_busWe;
    logic [31:0]      r_readData, r_busAddr, r_busWdata;
    logic [3:0]       r_busBe;

    logic        w_accept, w_misalign, w_setMisalign, w_setErr, w_capture;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shifted, w_loadData;

    assign w_accept   = (r_state == S_IDLE) & i_valid & (i_memRead | i_memWrite);
    assign w_misalign = ((i_funct3[1:0] == 2'b01) & i_memAddr[0])
                      | (i_funct3[1] & (i_memAddr[1:0] != 2'b00));

    // Store lane replication and byte enables; reads always enable every lane
    always_comb begin
        w_wdata = i_wrData;
        w_be    = 4'b1111;
        if (!i_funct3[1]) begin
            if (i_funct3[0]) begin
                w_wdata = {2{i_wrData[15:0]}};
                w_be    = 4'b0011 << {i_memAddr[1], 1'b0};
            end else begin
                w_wdata = {4{i_wrData[7:0]}};
                w_be    = 4'b0001 << i_memAddr[1:0];
            end
        end
        if (i_memRead) begin
            w_be = 4'b1111;
        end
    end

    // Load extraction from the addressed lane with sign/zero extension
    assign w_shifted = i_busRdata >> {r_lane, 3'b000};
    always_comb begin
        w_loadData = w_shifted;
        if (!r_funct3[1]) begin
            if (r_funct3[0]) begin
                w_loadData = r_funct3[2] ? {16'h0000, w_shifted[15:0]}
                                         : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end else begin
                w_loadData = r_funct3[2] ? {24'h000000, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
        end
    end

    // Next-state logic; gnt/rvalid take priority over an expiring timeout
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_setMisalign = 1'b0;
        w_setErr      = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_next = '0;
                    if (w_misalign) begin
                        w_state_next  = S_RESP;
                        w_setMisalign = 1'b1;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_busGnt) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_next = S_RESP;
                    w_setErr     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (i_busRvalid) begin
                    w_state_next = S_RESP;
                    w_capture    = r_isLoad;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_next = S_RESP;
                    w_setErr     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lane     <= 2'b00;
            r_funct3   <= 3'b000;
            r_isLoad   <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_busErr   <= 1'b0;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_readData <= 32'h0;
            r_busAddr  <= 32'h0;
            r_busWdata <= 32'h0;
            r_busBe    <= 4'h0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_done     <= (w_state_next == S_RESP);
            r_busReq   <= (w_state_next == S_REQ);
            r_misalign <= w_setMisalign;
            r_busErr   <= w_setErr;
            if (w_accept) begin
                r_lane   <= i_memAddr[1:0];
                r_funct3 <= i_funct3;
                r_isLoad <= i_memRead;
            end
            if (w_accept & ~w_misalign) begin
                r_busWe    <= ~i_memRead;
                r_busAddr  <= {i_memAddr[31:2], 2'b00};
                r_busWdata <= w_wdata;
                r_busBe    <= w_be;
            end
            if (w_capture) begin
                r_readData <= w_loadData;
            end else if (w_setMisalign | w_setErr) begin
                r_readData <= 32'h0;
            end
        end
    end

    assign o_stall    = w_accept | (r_state == S_REQ) | (r_state == S_WAIT);
    assign o_done     = r_done;
    assign o_readData = r_readData;
    assign o_misalign = r_misalign;
    assign o_busErr   = r_busErr;
    assign o_busReq   = r_busReq;
    assign o_busWe    = r_busWe;
    assign o_busAddr  = r_busAddr;
    assign o_busWdata = r_busWdata;
    assign o_busBe    = r_busBe;

endmodule
